// File: rtl/earom_ctrl.sv
// EAROM controller: CPU register file, pulse sequencer and read capture.
// Optional: EAROM_AUTO_ERASE_EN turns each write command into erase + write.
module earom_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic [5:0] ea_a,
    output logic [7:0] ea_din,
    input  logic [7:0] ea_dout,
    output logic       ea_c1,
    output logic       ea_c2,
    output logic       ea_cs1,
    output logic       ea_rstb,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_RECOVER,
        S_CAPTURE
    } state_t;

    localparam logic [1:0] M_WRITE = 2'b00;
    localparam logic [1:0] M_ERASE = 2'b01;
    localparam logic [1:0] M_READ  = 2'b10;
    localparam logic [1:0] M_NOP   = 2'b11;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] REC_LAST  = 8'(RECOVER_CYCLES - 1);
    localparam logic [7:0] RSTB_IDX  = 8'(HOLD_CYCLES / 2);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       reject_q, reject_d;
`ifdef EAROM_AUTO_ERASE_EN
    logic       wr_pend_q, wr_pend_d;
`endif

    logic cmd_wr;
    logic seq_end;

    assign busy     = (state_q != S_IDLE);
    assign cmd_wr   = cpu_wr && (cpu_addr == 2'd2) && !busy;
    assign ea_a     = addr_q;
    assign ea_din   = data_q;
    assign cpu_dout = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            mode_q   <= M_NOP;
            addr_q   <= 6'd0;
            data_q   <= 8'd0;
            dout_q   <= 8'd0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
`ifdef EAROM_AUTO_ERASE_EN
            wr_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            reject_q <= reject_d;
`ifdef EAROM_AUTO_ERASE_EN
            wr_pend_q <= wr_pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        seq_end = 1'b0;
`ifdef EAROM_AUTO_ERASE_EN
        wr_pend_d = wr_pend_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_wr && (cpu_din[1:0] != 2'b00)) begin
                    state_d = S_SETUP;
                    cnt_d   = 8'd0;
                    unique case (cpu_din[1:0])
                        2'b01: mode_d = M_READ;
`ifdef EAROM_AUTO_ERASE_EN
                        2'b10: begin
                            mode_d    = M_ERASE;
                            wr_pend_d = 1'b1;
                        end
`else
                        2'b10: mode_d = M_WRITE;
`endif
                        default: mode_d = M_ERASE;
                    endcase
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = 8'd0;
            end
            S_PULSE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RECOVER;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d = 8'd0;
`ifdef EAROM_AUTO_ERASE_EN
                    if (wr_pend_q) begin
                        state_d   = S_SETUP;
                        mode_d    = M_WRITE;
                        wr_pend_d = 1'b0;
                    end else
`endif
                    if (mode_q == M_READ) begin
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_IDLE;
                        seq_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                seq_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register file: reads see pre-write values; set events beat status-read clears.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        dout_d   = dout_q;
        done_d   = done_q;
        reject_d = reject_q;
        if (cpu_rd) begin
            unique case (cpu_addr)
                2'd0: dout_d = {2'b00, addr_q};
                2'd1: dout_d = data_q;
                2'd2: dout_d = {6'd0, mode_q};
                default: begin
                    dout_d   = {5'd0, done_q, reject_q, busy};
                    done_d   = 1'b0;
                    reject_d = 1'b0;
                end
            endcase
        end
        if (cpu_wr && !busy) begin
            if (cpu_addr == 2'd0) addr_d = cpu_din[5:0];
            if (cpu_addr == 2'd1) data_d = cpu_din;
        end
        if (cpu_wr && busy && (cpu_addr != 2'd3)) reject_d = 1'b1;
        if (state_q == S_CAPTURE) data_d = ea_dout;
        if (seq_end) done_d = 1'b1;
    end

    always_comb begin
        ea_c1   = 1'b1;
        ea_c2   = 1'b1;
        ea_cs1  = 1'b0;
        ea_rstb = 1'b0;
        unique case (state_q)
            S_SETUP, S_RECOVER: begin
                {ea_c1, ea_c2} = mode_q;
            end
            S_PULSE: begin
                {ea_c1, ea_c2} = mode_q;
                ea_cs1  = 1'b1;
                ea_rstb = (mode_q == M_READ) && (cnt_q == RSTB_IDX);
            end
            default: ;
        endcase
    end

endmodule
